tt_alu_accum: RTL and testbench
===============================

# tt_alu_accum

Parametrised, pipelined successor to the project's combinational adder/half-adder datapath. Accepts two WIDTH-bit operands and an opcode over a valid/ready handshake. Computes add, subtract, AND, XOR, accumulate or accumulator-clear, and returns a registered result with carry/zero flags. Sits between the Tiny Tapeout pin wrapper (ui_in/uio_in operands, uo_out result) and any downstream consumer that can apply backpressure.

## Interface

Parameters:
- WIDTH, 8, operand and result width (≥2)
- ACC_WIDTH, 16, accumulator width (≥ WIDTH)

Ports:
- clk  input  1  clock; one clock domain, all state on rising edge
- rst  input  1  synchronous, active-high reset; sampled on rising clk edge
- in_valid  input  1  operand/opcode valid
- in_ready  output  1  block can accept this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- op  input  3  opcode (see Operation)
- out_valid  output  1  result registers hold an unconsumed result
- out_ready  input  1  consumer takes result this cycle
- result  output  WIDTH  registered result
- carry  output  1  carry (ADD) / borrow (SUB); 0 for all other ops
- zero  output  1  result == 0
- acc  output  ACC_WIDTH  accumulator value (registered)
- acc_ovf  output  1  sticky accumulator overflow

## Operation

- Accept when in_valid && in_ready; a, b and op are sampled on that edge only.
- Opcodes:
  - 000 ADD: {carry,result} = a + b, computed in WIDTH+1 bits.
  - 001 SUB: result = a − b mod 2^WIDTH; carry = (a < b) unsigned.
  - 010 AND: result = a & b.
  - 011 XOR: result = a ^ b.
  - 100 ACC: acc ← acc + zero-extended a, mod 2^ACC_WIDTH. Result = low WIDTH bits of the new acc. If the addition carries out of ACC_WIDTH, acc_ovf ← 1.
  - 101 CLR: acc ← 0; acc_ovf ← 0; result = 0.
  - 110, 111 PASS: result = a.
- b is ignored for ACC, CLR and PASS.
- zero is derived from the result being registered. carry is 0 for every op except ADD/SUB.
- acc and acc_ovf update only on accepted ACC/CLR; they are unaffected by output backpressure.
- acc_ovf is sticky until CLR or rst.
- Output register holds result/carry/zero/out_valid.
  - Loaded on accept: out_valid ← 1.
  - Cleared (out_valid ← 0) when out_valid && out_ready and no new accept that cycle.
  - While out_valid && !out_ready, result/carry/zero are held stable.
- in_ready = !out_valid || out_ready (combinational from out_ready; a single-entry skid is not required). Pop and accept in the same cycle are allowed; the new result replaces the old one with out_valid staying 1.
- Reset: out_valid=0, result=0, carry=0, zero=0, acc=0, acc_ovf=0. in_ready is therefore 1 in the first cycle after reset.
- rst mid-operation: a pending unconsumed result is discarded. An input presented in the reset cycle is not accepted. rst has priority over every other event.

## Timing

- Latency: 1 cycle, accept edge → out_valid high with result.
- Throughput: 1 op/cycle while out_ready=1.
- acc reflects an ACC/CLR on the same edge the corresponding result becomes valid.
- No combinational path from a/b/op to any output. The only combinational path is out_ready → in_ready.
- Back-to-back ACC ops chain on the registered acc; no hazard.

## Test plan

- Arithmetic (WIDTH=8): ADD a=0xFF b=0x01 → next cycle out_valid=1, result=0x00, carry=1, zero=1. SUB 0x05−0x07 → 0xFE, carry=1. SUB 0x07−0x05 → 0x02, carry=0, zero=0.
- Logic/pass: AND 0xC3,0x5A → 0x42. XOR 0xC3,0x5A → 0x99. PASS a=0x3C → 0x3C. carry=0 for all three.
- Backpressure: out_ready=0, issue ADD 1+2 → result 3, out_valid=1, in_ready=0. Present SUB 9−4 for 3 cycles → not accepted, result stays 3. Raise out_ready → SUB accepted that cycle, result=5 next cycle.
- Accumulator (ACC_WIDTH=16): CLR, then 257×ACC a=0xFF → acc=0xFFFF, acc_ovf=0. ACC a=0x01 → acc=0x0000, acc_ovf=1, result=0x00, zero=1. ACC a=0x02 → acc=0x0002, acc_ovf still 1. CLR → acc=0, acc_ovf=0.
- Reset mid-operation: hold a result with out_ready=0 and acc=0x1234, assert rst one cycle with in_valid=1 → next cycle out_valid=0, result=0, acc=0, acc_ovf=0, in_ready=1, and no result appears for the input presented during reset.
- Streaming: out_ready=1, in_valid=1 for 10 cycles of ADD a=i, b=i → results 2i appear one per cycle in order, no gaps, no drops.

Source files
------------

// File: rtl/tt_alu_accum_if.sv
// Operand/result handshake bundle for tt_alu_accum.
// The slave side is the ALU and the master side is the producer/consumer.
interface tt_alu_accum_if #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned ACC_WIDTH = 16
) ();
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic [2:0]           op;
    logic                 out_valid;
    logic                 out_ready;
    logic [WIDTH-1:0]     result;
    logic                 carry;
    logic                 zero;
    logic [ACC_WIDTH-1:0] acc;
    logic                 acc_ovf;

    modport master (
        output in_valid, a, b, op, out_ready,
        input  in_ready, out_valid, result, carry, zero, acc, acc_ovf
    );

    modport slave (
        input  in_valid, a, b, op, out_ready,
        output in_ready, out_valid, result, carry, zero, acc, acc_ovf
    );
endinterface

// File: rtl/tt_alu_accum.sv
// Pipelined ALU with an accumulator: one-cycle latency, valid/ready on both sides.
// The result register is single-entry; in_ready opens whenever it is empty or being drained.
module tt_alu_accum #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned ACC_WIDTH = 16
) (
    input  logic           clk,
    input  logic           rst,
    tt_alu_accum_if.slave  bus
);
    localparam int unsigned WW1 = WIDTH + 1;
    localparam int unsigned AW1 = ACC_WIDTH + 1;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;
    localparam logic [2:0] OP_ACC = 3'b100;
    localparam logic [2:0] OP_CLR = 3'b101;

    logic [WIDTH-1:0]     r_result;
    logic                 r_carry;
    logic                 r_zero;
    logic                 r_out_valid;
    logic [ACC_WIDTH-1:0] r_acc;
    logic                 r_acc_ovf;

    logic                 w_in_ready;
    logic                 w_accept;
    logic [WW1-1:0]       w_sum;
    logic [AW1-1:0]       w_acc_sum;
    logic [WIDTH-1:0]     w_res;
    logic                 w_carry;
    logic                 w_acc_we;
    logic [ACC_WIDTH-1:0] w_acc_nxt;
    logic                 w_ovf_nxt;

    assign w_in_ready = !r_out_valid || bus.out_ready;
    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_sum      = WW1'(bus.a) + WW1'(bus.b);
    assign w_acc_sum  = AW1'(r_acc) + AW1'(bus.a);

    // Opcode decode; PASS covers both unassigned encodings.
    always_comb begin
        w_res     = bus.a;
        w_carry   = 1'b0;
        w_acc_we  = 1'b0;
        w_acc_nxt = r_acc;
        w_ovf_nxt = r_acc_ovf;
        case (bus.op)
            OP_ADD: begin
                w_res   = w_sum[WIDTH-1:0];
                w_carry = w_sum[WIDTH];
            end
            OP_SUB: begin
                w_res   = bus.a - bus.b;
                w_carry = (bus.a < bus.b);
            end
            OP_AND: w_res = bus.a & bus.b;
            OP_XOR: w_res = bus.a ^ bus.b;
            OP_ACC: begin
                w_acc_we  = 1'b1;
                w_acc_nxt = w_acc_sum[ACC_WIDTH-1:0];
                w_ovf_nxt = r_acc_ovf | w_acc_sum[ACC_WIDTH];
                w_res     = w_acc_sum[WIDTH-1:0];
            end
            OP_CLR: begin
                w_acc_we  = 1'b1;
                w_acc_nxt = '0;
                w_ovf_nxt = 1'b0;
                w_res     = '0;
            end
            default: w_res = bus.a;
        endcase
    end

    // Output register and accumulator; a new accept wins over a plain pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_carry     <= 1'b0;
            r_zero      <= 1'b0;
            r_acc       <= '0;
            r_acc_ovf   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_out_valid <= 1'b1;
                r_result    <= w_res;
                r_carry     <= w_carry;
                r_zero      <= (w_res == '0);
            end else if (r_out_valid && bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
            if (w_accept && w_acc_we) begin
                r_acc     <= w_acc_nxt;
                r_acc_ovf <= w_ovf_nxt;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.result    = r_result;
    assign bus.carry     = r_carry;
    assign bus.zero      = r_zero;
    assign bus.acc       = r_acc;
    assign bus.acc_ovf   = r_acc_ovf;
endmodule

// File: tb/tb_tt_alu_accum.sv
// Directed bench for tt_alu_accum: expected results are queued on accept and
// compared on each output handshake; accumulator state is tracked by a reference model.
module tb_tt_alu_accum;
    localparam int unsigned WIDTH     = 8;
    localparam int unsigned ACC_WIDTH = 16;

    localparam logic [2:0] ADD = 3'b000;
    localparam logic [2:0] SUB = 3'b001;
    localparam logic [2:0] AND = 3'b010;
    localparam logic [2:0] XOR = 3'b011;
    localparam logic [2:0] ACC = 3'b100;
    localparam logic [2:0] CLR = 3'b101;
    localparam logic [2:0] PAS = 3'b111;

    typedef struct packed {
        logic [7:0] res;
        logic       c;
        logic       z;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    tt_alu_accum_if #(.WIDTH(WIDTH), .ACC_WIDTH(ACC_WIDTH)) bus ();

    tt_alu_accum #(.WIDTH(WIDTH), .ACC_WIDTH(ACC_WIDTH)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t        sb[$];
    logic [15:0] m_acc;
    logic        m_ovf;
    int          n_cmp;
    int          n_err;
    int          n_pop;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        exp_t        e;
        logic [8:0]  s;
        logic [16:0] t;
        e = '0;
        case (op)
            ADD: begin s = {1'b0, a} + {1'b0, b}; e.res = s[7:0]; e.c = s[8]; end
            SUB: begin e.res = a - b; e.c = (a < b); end
            AND: e.res = a & b;
            XOR: e.res = a ^ b;
            ACC: begin
                t = {1'b0, m_acc} + {9'b0, a};
                if (t[16]) m_ovf = 1'b1;
                m_acc = t[15:0];
                e.res = t[7:0];
            end
            CLR: begin m_acc = '0; m_ovf = 1'b0; e.res = '0; end
            default: e.res = a;
        endcase
        e.z = (e.res == 8'h00);
        return e;
    endfunction

    // One clock: drive, score the handshakes seen before the edge, then check acc after it.
    task automatic step(input logic v, input logic [2:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic ordy);
        exp_t e;
        bus.in_valid  = v;
        bus.op        = op;
        bus.a         = a;
        bus.b         = b;
        bus.out_ready = ordy;
        #1;
        if (bus.out_valid && bus.out_ready) begin
            n_pop++;
            chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("sb_result", 32'(bus.result), 32'(e.res));
                chk("sb_carry",  32'(bus.carry),  32'(e.c));
                chk("sb_zero",   32'(bus.zero),   32'(e.z));
            end
        end
        if (bus.in_valid && bus.in_ready) sb.push_back(model(op, a, b));
        @(posedge clk);
        #1;
        chk("acc",     32'(bus.acc),     32'(m_acc));
        chk("acc_ovf", 32'(bus.acc_ovf), 32'(m_ovf));
    endtask

    initial begin
        int pops0;
        n_cmp = 0; n_err = 0; n_pop = 0;
        m_acc = '0; m_ovf = 1'b0;
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.op = ADD; bus.a = '0; bus.b = '0; bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_result",    32'(bus.result),    32'd0);
        chk("rst_carry",     32'(bus.carry),     32'd0);
        chk("rst_zero",      32'(bus.zero),      32'd0);
        chk("rst_acc",       32'(bus.acc),       32'd0);
        chk("rst_acc_ovf",   32'(bus.acc_ovf),   32'd0);
        chk("rst_in_ready",  32'(bus.in_ready),  32'd1);

        // Arithmetic and logic
        step(1'b1, ADD, 8'hFF, 8'h01, 1'b1);
        chk("add_valid", 32'(bus.out_valid), 32'd1);
        chk("add_res",   32'(bus.result),    32'h00);
        chk("add_carry", 32'(bus.carry),     32'd1);
        chk("add_zero",  32'(bus.zero),      32'd1);
        step(1'b1, SUB, 8'h05, 8'h07, 1'b1);
        chk("sub_res",   32'(bus.result),    32'hFE);
        chk("sub_borrow",32'(bus.carry),     32'd1);
        step(1'b1, SUB, 8'h07, 8'h05, 1'b1);
        step(1'b1, AND, 8'hC3, 8'h5A, 1'b1);
        chk("and_res",   32'(bus.result),    32'h42);
        step(1'b1, XOR, 8'hC3, 8'h5A, 1'b1);
        chk("xor_res",   32'(bus.result),    32'h99);
        step(1'b1, PAS, 8'h3C, 8'hFF, 1'b1);
        step(1'b1, 3'b110, 8'h00, 8'h77, 1'b1);
        step(1'b0, ADD, 8'h00, 8'h00, 1'b1);
        chk("drain_valid", 32'(bus.out_valid), 32'd0);

        // Backpressure
        step(1'b1, ADD, 8'h01, 8'h02, 1'b0);
        chk("bp_valid",    32'(bus.out_valid), 32'd1);
        chk("bp_res",      32'(bus.result),    32'd3);
        chk("bp_in_ready", 32'(bus.in_ready),  32'd0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, SUB, 8'h09, 8'h04, 1'b0);
            chk("bp_hold", 32'(bus.result), 32'd3);
        end
        step(1'b1, SUB, 8'h09, 8'h04, 1'b1);
        chk("bp_next", 32'(bus.result), 32'd5);
        step(1'b0, ADD, 8'h00, 8'h00, 1'b1);

        // Accumulator wrap and sticky overflow
        step(1'b1, CLR, 8'h00, 8'h00, 1'b1);
        for (int i = 0; i < 257; i++) step(1'b1, ACC, 8'hFF, 8'h00, 1'b1);
        chk("acc_full",     32'(bus.acc),     32'hFFFF);
        chk("acc_full_ovf", 32'(bus.acc_ovf), 32'd0);
        step(1'b1, ACC, 8'h01, 8'h00, 1'b1);
        chk("acc_wrap",     32'(bus.acc),     32'h0000);
        chk("acc_wrap_ovf", 32'(bus.acc_ovf), 32'd1);
        chk("acc_wrap_res", 32'(bus.result),  32'h00);
        chk("acc_wrap_z",   32'(bus.zero),    32'd1);
        step(1'b1, ACC, 8'h02, 8'h00, 1'b1);
        chk("acc_sticky",   32'(bus.acc_ovf), 32'd1);
        step(1'b1, CLR, 8'h00, 8'h00, 1'b1);
        chk("clr_acc",      32'(bus.acc),     32'd0);
        chk("clr_ovf",      32'(bus.acc_ovf), 32'd0);

        // Reset with a held result and a non-trivial accumulator
        for (int i = 0; i < 18; i++) step(1'b1, ACC, 8'hFF, 8'h00, 1'b1);
        step(1'b1, ACC, 8'h46, 8'h00, 1'b1);
        chk("pre_rst_acc", 32'(bus.acc), 32'h1234);
        rst = 1'b1;
        bus.in_valid = 1'b1; bus.op = ADD; bus.a = 8'h07; bus.b = 8'h08; bus.out_ready = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.in_valid = 1'b0;
        sb.delete();
        m_acc = '0; m_ovf = 1'b0;
        chk("mrst_valid",    32'(bus.out_valid), 32'd0);
        chk("mrst_result",   32'(bus.result),    32'd0);
        chk("mrst_acc",      32'(bus.acc),       32'd0);
        chk("mrst_ovf",      32'(bus.acc_ovf),   32'd0);
        chk("mrst_in_ready", 32'(bus.in_ready),  32'd1);
        step(1'b0, ADD, 8'h00, 8'h00, 1'b1);
        chk("mrst_no_ghost", 32'(bus.out_valid), 32'd0);

        // Streaming at full rate
        pops0 = n_pop;
        for (int i = 0; i < 10; i++) begin
            step(1'b1, ADD, 8'(i), 8'(i), 1'b1);
            chk("stream_valid", 32'(bus.out_valid), 32'd1);
        end
        step(1'b0, ADD, 8'h00, 8'h00, 1'b1);
        chk("stream_pops",  32'(n_pop - pops0), 32'd10);
        chk("sb_drained",   32'(sb.size()),     32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
